// File: rtl/div_scheduler.sv
// div_scheduler: two requesters share one iterative restoring divider.
// A request is accepted in IDLE, the divider produces one quotient bit per
// cycle (MSB first) and the result is presented with a one-cycle strobe.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting; requests are sampled and arbitrated round-robin
// S_CALC | one restoring-division iteration per clock, p_N iterations
// S_DONE | result registered, o_valid high for this single cycle
module div_scheduler #(
   parameter int p_N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_req0,
   input  logic [p_N-1:0] i_a0,
   input  logic [p_N-1:0] i_b0,
   input  logic           i_req1,
   input  logic [p_N-1:0] i_a1,
   input  logic [p_N-1:0] i_b1,
   output logic           o_gnt0,
   output logic           o_gnt1,
   output logic           o_busy,
   output logic           o_valid,
   output logic [p_N-1:0] o_q,
   output logic [p_N-1:0] o_r,
   output logic           o_id,
   output logic           o_dbz
);

   localparam int CW = $clog2(p_N);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t         state_q;
   logic [CW-1:0]  cnt_q;
   // dvd_q shifts dividend bits out of the top and quotient bits in at the
   // bottom, so after p_N iterations it holds the quotient
   logic [p_N-1:0] dvd_q;
   logic [p_N-1:0] b_q;
   logic [p_N:0]   rem_q;
   logic           id_q;
   logic           last_q;

   logic           gnt0_q;
   logic           gnt1_q;
   logic           busy_q;
   logic           valid_q;
   logic [p_N-1:0] q_q;
   logic [p_N-1:0] r_q;
   logic           oid_q;
   logic           dbz_q;

   logic [p_N:0]   shift_d;
   logic           qbit_d;
   logic [p_N:0]   rem_d;
   logic [p_N-1:0] dvd_d;
   logic           win1_d;

   // one restoring iteration plus round-robin winner selection
   always_comb begin
      shift_d = (rem_q << 1) | {{p_N{1'b0}}, dvd_q[p_N-1]};
      qbit_d  = (shift_d >= {1'b0, b_q});
      rem_d   = qbit_d ? (shift_d - {1'b0, b_q}) : shift_d;
      dvd_d   = {dvd_q[p_N-2:0], qbit_d};
      // on a tie the requester not granted last wins
      win1_d  = i_req1 & (~i_req0 | ~last_q);
   end

   // sequencing FSM, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
         oid_q   <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_req0 || i_req1) begin
                  state_q <= S_CALC;
                  cnt_q   <= '0;
                  rem_q   <= '0;
                  busy_q  <= 1'b1;
                  id_q    <= win1_d;
                  last_q  <= win1_d;
                  gnt0_q  <= ~win1_d;
                  gnt1_q  <= win1_d;
                  dvd_q   <= win1_d ? i_a1 : i_a0;
                  b_q     <= win1_d ? i_b1 : i_b0;
               end
            end
            S_CALC: begin
               rem_q <= rem_d;
               dvd_q <= dvd_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(p_N - 1)) begin
                  state_q <= S_DONE;
                  valid_q <= 1'b1;
                  q_q     <= dvd_d;
                  r_q     <= rem_d[p_N-1:0];
                  oid_q   <= id_q;
                  // a zero divisor naturally yields all-ones and the dividend
                  dbz_q   <= (b_q == '0);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_gnt0  = gnt0_q;
   assign o_gnt1  = gnt1_q;
   assign o_busy  = busy_q;
   assign o_valid = valid_q;
   assign o_q     = q_q;
   assign o_r     = r_q;
   assign o_id    = oid_q;
   assign o_dbz   = dbz_q;

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler (p_N = 8): table of request vectors with expected
// grant and result, a scoreboard queue checked by a result monitor, and
// hand-written sequences for reset abort and back-to-back operation.
module tb_div_scheduler;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_req0, i_req1;
   logic [N-1:0] i_a0, i_b0, i_a1, i_b1;
   logic         o_gnt0, o_gnt1, o_busy, o_valid, o_id, o_dbz;
   logic [N-1:0] o_q, o_r;

   typedef struct {
      logic       r0;
      logic       r1;
      logic [7:0] a0;
      logic [7:0] b0;
      logic [7:0] a1;
      logic [7:0] b1;
      int         gnt;
      logic [7:0] q;
      logic [7:0] r;
      logic       dbz;
   } vec_t;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       id;
      logic       dbz;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   n_push   = 0;
   int   n_valid  = 0;
   vec_t tbl[9];

   div_scheduler #(.p_N(N)) dut (
      .clk    (clk),
      .rst    (rst),
      .i_req0 (i_req0),
      .i_a0   (i_a0),
      .i_b0   (i_b0),
      .i_req1 (i_req1),
      .i_a1   (i_a1),
      .i_b1   (i_b1),
      .o_gnt0 (o_gnt0),
      .o_gnt1 (o_gnt1),
      .o_busy (o_busy),
      .o_valid(o_valid),
      .o_q    (o_q),
      .o_r    (o_r),
      .o_id   (o_id),
      .o_dbz  (o_dbz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r0, input logic r1,
                               input logic [7:0] a0, input logic [7:0] b0,
                               input logic [7:0] a1, input logic [7:0] b1,
                               input int gnt, input logic [7:0] q,
                               input logic [7:0] r, input logic dbz);
      vec_t v;
      v.r0 = r0; v.r1 = r1; v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
      v.gnt = gnt; v.q = q; v.r = r; v.dbz = dbz;
      return v;
   endfunction

   // result monitor: every o_valid must match the oldest expected result
   always @(negedge clk) begin
      if (o_valid) begin
         exp_t e;
         n_valid++;
         if (sb.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("result_q", int'(o_q), int'(e.q));
            chk("result_r", int'(o_r), int'(e.r));
            chk("result_id", int'(o_id), int'(e.id));
            chk("result_dbz", int'(o_dbz), int'(e.dbz));
         end
      end
   end

   task automatic push_exp(input logic [7:0] q, input logic [7:0] r,
                           input logic id, input logic dbz);
      exp_t e;
      e.q = q; e.r = r; e.id = id; e.dbz = dbz;
      sb.push_back(e);
      n_push++;
   endtask

   // returns 0/1 for the granted requester, -1 on timeout
   task automatic wait_grant(output int who);
      who = -1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (o_gnt0 || o_gnt1) begin
            who = o_gnt1 ? 1 : 0;
            chk("gnt_onehot", int'(o_gnt0 & o_gnt1), 0);
            chk("busy_at_grant", int'(o_busy), 1);
            return;
         end
      end
      chk("grant_timeout", 0, 1);
   endtask

   // count negedges from the grant cycle until o_valid (bounded)
   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) chk("gnt_one_cycle", int'(o_gnt0 | o_gnt1), 0);
      end while (!o_valid && lat < 20);
   endtask

   // called at a negedge; returns at the negedge of the following IDLE cycle
   task automatic run_vec(input vec_t v);
      int who, lat;
      i_req0 = v.r0; i_req1 = v.r1;
      i_a0 = v.a0; i_b0 = v.b0; i_a1 = v.a1; i_b1 = v.b1;
      wait_grant(who);
      chk("gnt_winner", who, v.gnt);
      if (who < 0) return;
      push_exp(v.q, v.r, v.gnt[0], v.dbz);
      // winner drops its request and scrambles operands mid-operation
      if (who == 0) begin
         i_req0 = 1'b0; i_a0 = 8'($urandom); i_b0 = 8'($urandom);
      end else begin
         i_req1 = 1'b0; i_a1 = 8'($urandom); i_b1 = 8'($urandom);
      end
      wait_valid(lat);
      chk("latency", lat, N);
      @(negedge clk);
      chk("valid_one_cycle", int'(o_valid), 0);
      chk("busy_idle_gap", int'(o_busy), 0);
      chk("q_held", int'(o_q), int'(v.q));
   endtask

   initial begin
      int who, lat, gap, lows;
      logic [7:0] ra, rb;
      vec_t rv;

      // tie after reset -> req0, req1 still held -> req1, tie again -> req0
      tbl[0] = mk(1'b1, 1'b1, 8'd200, 8'd3, 8'd100, 8'd10, 0, 8'd66, 8'd2, 1'b0);
      tbl[1] = mk(1'b0, 1'b1, 8'd0, 8'd0, 8'd100, 8'd10, 1, 8'd10, 8'd0, 1'b0);
      tbl[2] = mk(1'b1, 1'b1, 8'd14, 8'd7, 8'd37, 8'd0, 0, 8'd2, 8'd0, 1'b0);
      tbl[3] = mk(1'b0, 1'b1, 8'd0, 8'd0, 8'd37, 8'd0, 1, 8'd255, 8'd37, 1'b1);
      tbl[4] = mk(1'b1, 1'b0, 8'd5, 8'd9, 8'd0, 8'd0, 0, 8'd0, 8'd5, 1'b0);
      tbl[5] = mk(1'b0, 1'b1, 8'd0, 8'd0, 8'd255, 8'd1, 1, 8'd255, 8'd0, 1'b0);
      tbl[6] = mk(1'b1, 1'b0, 8'd255, 8'd255, 8'd0, 8'd0, 0, 8'd1, 8'd0, 1'b0);
      // last grant was req0, so this tie goes to req1
      tbl[7] = mk(1'b1, 1'b1, 8'd0, 8'd5, 8'd9, 8'd4, 1, 8'd2, 8'd1, 1'b0);
      tbl[8] = mk(1'b1, 1'b0, 8'd0, 8'd5, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1'b0);

      rst = 1'b1; i_req0 = 1'b0; i_req1 = 1'b0;
      i_a0 = '0; i_b0 = '0; i_a1 = '0; i_b1 = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_outputs",
          int'({o_gnt0, o_gnt1, o_busy, o_valid, o_q, o_r, o_id, o_dbz}), 0);

      foreach (tbl[i]) run_vec(tbl[i]);

      // random single-requester divisions against a reference model
      for (int k = 0; k < 4; k++) begin
         ra = 8'($urandom);
         rb = (k == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         if (k[0]) rv = mk(1'b0, 1'b1, 8'd0, 8'd0, ra, rb, 1,
                           (rb == 0) ? 8'hFF : ra / rb, (rb == 0) ? ra : ra % rb,
                           rb == 0);
         else      rv = mk(1'b1, 1'b0, ra, rb, 8'd0, 8'd0, 0,
                           (rb == 0) ? 8'hFF : ra / rb, (rb == 0) ? ra : ra % rb,
                           rb == 0);
         run_vec(rv);
      end

      // make sure o_q is non-zero before the reset-abort sequence
      run_vec(mk(1'b1, 1'b0, 8'd100, 8'd7, 8'd0, 8'd0, 0, 8'd14, 8'd2, 1'b0));

      // reset during the 4th CALC cycle aborts with no result
      i_req0 = 1'b1; i_a0 = 8'd100; i_b0 = 8'd7;
      wait_grant(who);
      chk("abort_grant", who, 0);
      i_req0 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      chk("abort_outputs",
          int'({o_gnt0, o_gnt1, o_busy, o_valid, o_q, o_r, o_id, o_dbz}), 0);
      repeat (12) @(negedge clk);
      // last-granted is back to 1, so the tie goes to req0
      run_vec(mk(1'b1, 1'b1, 8'd77, 8'd8, 8'd9, 8'd3, 0, 8'd9, 8'd5, 1'b0));
      i_req1 = 1'b0;
      @(negedge clk);
      sb.delete();
      repeat (12) @(negedge clk);

      // req0 held continuously: grants every 10 cycles, one idle cycle between
      i_req0 = 1'b1; i_a0 = 8'd50; i_b0 = 8'd6;
      wait_grant(who);
      chk("held_first_grant", who, 0);
      push_exp(8'd8, 8'd2, 1'b0, 1'b0);
      for (int g = 0; g < 2; g++) begin
         gap = 0; lows = 0;
         do begin
            @(negedge clk);
            gap++;
            if (!o_busy) lows++;
         end while (!(o_gnt0 || o_gnt1) && gap < 30);
         chk("held_grant_spacing", gap, N + 2);
         chk("held_busy_low_cycles", lows, 1);
         push_exp(8'd8, 8'd2, 1'b0, 1'b0);
      end
      i_req0 = 1'b0;
      wait_valid(lat);
      chk("held_last_latency", lat, N);
      repeat (4) @(negedge clk);

      chk("valid_count", n_valid, n_push);
      chk("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0d required=%0d", 1, 0);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/div_scheduler.md
DIV_SCHEDULER -- requirements
Module: div_scheduler

Interface
REQ-001 Parameter p_N, default 8, operand/result width in bits (p_N >= 2).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_req0  input  1  requester 0 division request, level.
REQ-005 i_a0, i_b0  input  p_N each  requester 0 dividend, divisor.
REQ-006 i_req1  input  1  requester 1 division request, level.
REQ-007 i_a1, i_b1  input  p_N each  requester 1 dividend, divisor.
REQ-008 o_gnt0, o_gnt1  output  1 each  one-cycle grant pulse; operands captured.
REQ-009 o_busy  output  1  high while an operation is in progress.
REQ-010 o_valid  output  1  one-cycle result strobe.
REQ-011 o_q, o_r  output  p_N each  quotient, remainder.
REQ-012 o_id  output  1  index of the requester that owns the current result.
REQ-013 o_dbz  output  1  divide-by-zero flag for the current result.

Function
REQ-014 The block SHALL share one internal iterative restoring divider (one quotient bit per cycle, MSB first) between two requesters.
REQ-015 The FSM SHALL have states IDLE, CALC, DONE; IDLE->CALC on a sampled request; CALC->DONE after p_N iterations; DONE->IDLE unconditionally.
REQ-016 In IDLE with any request high at edge E0: latch the winner's a/b and id, clear the iteration counter, enter CALC, and assert that requester's o_gnt for exactly the cycle after E0.
REQ-017 Arbitration SHALL be round-robin: a single request wins outright; on simultaneous requests the requester not granted last wins; the last-granted register resets to 1 so requester 0 wins the first tie.
REQ-018 Requests SHALL be sampled only in IDLE; requests arriving in CALC/DONE wait, and a request still high after its grant counts as a new request.
REQ-019 Edges E1..Ep_N SHALL each perform one iteration: shift partial remainder left taking the next dividend bit, subtract divisor, restore if negative, shift the quotient bit in; the partial remainder is p_N+1 bits wide.
REQ-020 At edge Ep_N the FSM SHALL enter DONE and register o_q, o_r, o_id, o_dbz with o_valid=1 for exactly one cycle; a result SHALL therefore be visible p_N cycles after the grant cycle.
REQ-021 o_q, o_r, o_id, o_dbz SHALL hold their values until the next DONE entry or reset.
REQ-022 Divisor 0 SHALL use the same latency; result SHALL be o_q = all ones, o_r = dividend, o_dbz=1; o_dbz=0 otherwise.
REQ-023 o_busy SHALL be 1 in CALC and DONE, 0 in IDLE; minimum spacing between sampling edges is p_N+2 cycles.
REQ-024 Operand inputs SHALL be ignored after capture; changing them mid-operation SHALL not affect the result.
REQ-025 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-026 With rst high at an edge, the block SHALL enter IDLE and zero o_gnt0, o_gnt1, o_busy, o_valid, o_q, o_r, o_id, o_dbz, the counter and operand registers; last-granted SHALL be 1.
REQ-027 Reset in CALC or DONE SHALL abort the operation with no o_valid pulse; rst has priority over every other event in the same cycle.

Verification (p_N=8)
REQ-028 Req0 a=14 b=7 sampled at E0 -> o_gnt0 high cycle after E0, o_valid at E8: q=2 r=0 id=0 dbz=0.
REQ-029 Req0 (200/3) and req1 (100/10) raised together and held until grant -> req0 first (q=66 r=2 id=0), then req1 (q=10 r=0 id=1); a further tie goes to req0.
REQ-030 Req1 a=37 b=0 -> q=255 r=37 dbz=1 id=1, same latency as REQ-028.
REQ-031 Boundaries: 5/9 -> q=0 r=5; 255/1 -> q=255 r=0; 255/255 -> q=1 r=0.
REQ-032 rst pulsed during the 4th CALC cycle -> next cycle all outputs 0, no o_valid; a subsequent req0/req1 tie grants req0.
REQ-033 Req0 held high continuously -> grants every 10 cycles, one o_valid per grant; o_busy low exactly one cycle between operations.
